regfile_wb_queue: RTL

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_wb_queue.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_wb_queue.sv
// Writeback queue that lets long-latency units (multicycle/AES) share the regfile write port,
// draining in acceptance order whenever the core's own writeback leaves the port idle.
module regfile_wb_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [4:0]                 req_rd,
  input  logic [XLEN-1:0]            req_data,
  input  logic                       core_wb_busy,
  output logic                       wb_enable,
  output logic [4:0]                 wb_rd,
  output logic [XLEN-1:0]            wb_data,
  input  logic [4:0]                 rs1_address,
  input  logic [4:0]                 rs2_address,
  output logic                       rs1_pending,
  output logic                       rs2_pending,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       rd_mem_q   [DEPTH];
  logic [4:0]       rd_mem_d   [DEPTH];
  logic [XLEN-1:0]  data_mem_q [DEPTH];
  logic [XLEN-1:0]  data_mem_d [DEPTH];
  logic [DEPTH-1:0] occ;
  logic             push_en;
  logic             pop;

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign req_ready = (count_q < CNT_W'(DEPTH));
  assign wb_enable = !empty && !core_wb_busy;
  assign pop       = wb_enable;
  assign wb_rd     = rd_mem_q[head_q];
  assign wb_data   = data_mem_q[head_q];

  // Writes to x0 are accepted but dropped; nothing is stored while reset is asserted.
  assign push_en = req_valid && req_ready && (req_rd != 5'd0) && !reset;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push_en) begin
      rd_mem_d[tail_q]   = req_rd;
      data_mem_d[tail_q] = req_data;
      tail_d             = tail_q + PTR_W'(1);
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  // An entry is live when its distance from head (mod DEPTH) is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_occ
    logic [PTR_W-1:0] off;
    assign off    = PTR_W'(i) - head_q;
    assign occ[i] = ({1'b0, off} < count_q);
  end

  always_comb begin
    rs1_pending = 1'b0;
    rs2_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && (rd_mem_q[i] == rs1_address) && (rs1_address != 5'd0)) rs1_pending = 1'b1;
      if (occ[i] && (rd_mem_q[i] == rs2_address) && (rs2_address != 5'd0)) rs2_pending = 1'b1;
    end
  end

endmodule
